exec_wb_unit: RTL
=================

# exec_wb_unit

Write-back and completion unit that sits downstream of the RV32IM execute stage. It collects single-cycle ALU results and multi-cycle results from the multiplier, the divider and the load path. It holds the execute stage stalled while a multi-cycle operation is outstanding. It drives one registered register-file write port, which also serves as the forwarding source.

## Interface
- W, 32, datapath width
- TIMEOUT, 64, max cycles waited for mul_rdy/div_rdy/ld_valid before abort (≥2)

- clk  in  1  clock, all state on rising edge
- a_rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  execute stage presents an instruction this cycle
- ex_kind  in  2  00 ALU, 01 MUL, 10 DIV, 11 LOAD
- alu_rslt_mux_sel  in  2  ALU source: 00 adder_result[W-1:0], 01 shft_result, 10 arth_log_result, 11 jmp_pc4
- ex_funct3  in  3  load size: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ex_rd  in  5  destination register
- ex_useRd  in  1  instruction writes rd
- adder_result  in  W+2  adder output; bits [1:0] are the load byte offset
- shft_result, arth_log_result, jmp_pc4  in  W  ALU results
- mul_result, div_result  in  W  multiplier/divider results
- mul_rdy, div_rdy  in  1  unit result valid (sampled only in matching wait state)
- ld_valid  in  1  load data valid; ld_data  in  W  aligned memory word
- stall_ex  out  1  hold execute stage (combinational)
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  write address (registered)
- rf_wdata  out  W  write data (registered)
- wb_err  out  1  one-cycle pulse on timeout abort (registered)

## Operation
- States: IDLE, WAIT_MUL, WAIT_DIV, WAIT_LD.
- IDLE, ex_valid and ex_kind=ALU:
  - write the selected ALU result next cycle
  - rf_we = ex_useRd && ex_rd≠0
  - state stays IDLE
- IDLE, ex_valid and ex_kind≠ALU:
  - capture ex_rd, ex_useRd, ex_funct3 and adder_result[1:0]
  - clear the wait counter
  - go to WAIT_MUL / WAIT_DIV / WAIT_LD
- WAIT_MUL: on mul_rdy, write mul_result and return to IDLE. div_rdy and ld_valid are ignored.
- WAIT_DIV: on div_rdy, write div_result and return to IDLE. Other ready signals are ignored.
- WAIT_LD: on ld_valid, extract from ld_data using the captured offset, write, and return to IDLE.
  - LB/LBU take byte [8·off+7:8·off]; LH/LHU take half [16·off[1]+15:16·off[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
  - Any other funct3 is treated as LW.
- Writes to x0 or with useRd=0 never assert rf_we; the FSM still completes normally.
- Wait counter increments every cycle in a WAIT state. When it reaches TIMEOUT-1 with no ready:
  - pulse wb_err next cycle
  - perform no write
  - return to IDLE
- Ready arriving in the same cycle as the timeout terminal count wins: the write happens and wb_err stays 0.
- ex_valid is ignored in WAIT states, because upstream is stalled.
- stall_ex = (state≠IDLE) || (state=IDLE && ex_valid && ex_kind≠ALU).

## Timing
- Reset values: state IDLE, counter 0, rf_we 0, rf_waddr 0, rf_wdata 0, wb_err 0.
- Reset asserted mid-operation aborts immediately. The pending write is dropped and no wb_err is issued.
- ALU latency: ex_valid in cycle N gives rf_we in cycle N+1, for one cycle only.
- MUL/DIV/LD: ready in cycle M gives rf_we in cycle M+1. The FSM is back in IDLE at M+1, so stall_ex deasserts in M+1 and a new ex_valid is accepted in M+1.
- stall_ex is high from the accept cycle through cycle M inclusive.
- Back-to-back ALU instructions: one write per cycle, no bubbles.
- rf_we never asserts in the cycle directly after a timeout.
- Only rf_waddr and rf_wdata change together with rf_we. Between writes they hold their last value.

## Test plan
- Reset then ALU:
  - ex_valid, kind=ALU, sel=01, shft_result=0x0000_00F0, rd=5 → cycle+1: rf_we=1, waddr=5, wdata=0xF0; stall_ex=0 throughout.
  - Repeat with rd=0 → rf_we=0.
- MUL handshake:
  - accept MUL rd=7, hold mul_rdy low 10 cycles (stall_ex=1), pulse div_rdy in cycle 3 (ignored)
  - mul_rdy with 0x1234_5678 → next cycle rf_we=1, waddr=7, wdata=0x1234_5678, stall_ex=0.
- Load extraction:
  - ld_data=0x8081_8283, offset=2:
  - LB → 0xFFFF_FF81
  - LBU → 0x0000_0081
  - LH → 0xFFFF_8081
  - LHU → 0x0000_8081
  - LW at offset 0 → 0x8081_8283.
- Timeout, TIMEOUT=8:
  - DIV with div_rdy never asserted → wb_err pulses exactly once, no rf_we, IDLE afterwards.
  - Repeat with div_rdy in the terminal-count cycle → write occurs, wb_err=0.
- Reset mid-wait:
  - assert a_rst asynchronously during WAIT_LD → outputs 0 immediately
  - ld_valid after reset release → no write.
- Back-to-back: three ALU instructions in consecutive cycles, then MUL → three consecutive writes, then stall until mul_rdy.

Source files
------------

// File: rtl/exec_wb_unit.sv
// exec_wb_unit
// Write-back and completion unit downstream of the RV32IM execute stage.
// It retires single-cycle ALU results directly and parks on multi-cycle
// operations (multiply, divide, load) until the matching unit reports ready
// or the wait counter expires. One registered register-file write port is
// produced, and it doubles as the forwarding source.
//
// Ports:
//   clk, a_rst          clock (rising edge) and asynchronous active-high reset
//   ex_valid, ex_kind   instruction present / class (00 ALU, 01 MUL, 10 DIV, 11 LOAD)
//   alu_rslt_mux_sel    ALU source select (adder, shifter, arith/logic, pc+4)
//   ex_funct3           load size encoding
//   ex_rd, ex_useRd     destination register and its write qualifier
//   adder_result        adder output, low two bits double as load byte offset
//   shft_result, arth_log_result, jmp_pc4   other ALU sources
//   mul_result/mul_rdy, div_result/div_rdy  multiplier and divider results
//   ld_data/ld_valid    aligned memory word and its valid strobe
//   stall_ex            hold execute stage (combinational)
//   rf_we, rf_waddr, rf_wdata   registered register-file write port
//   wb_err              one-cycle pulse when a multi-cycle wait is abandoned
module exec_wb_unit #(
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         a_rst,
    input  logic         ex_valid,
    input  logic [1:0]   ex_kind,
    input  logic [1:0]   alu_rslt_mux_sel,
    input  logic [2:0]   ex_funct3,
    input  logic [4:0]   ex_rd,
    input  logic         ex_useRd,
    input  logic [W+1:0] adder_result,
    input  logic [W-1:0] shft_result,
    input  logic [W-1:0] arth_log_result,
    input  logic [W-1:0] jmp_pc4,
    input  logic [W-1:0] mul_result,
    input  logic [W-1:0] div_result,
    input  logic         mul_rdy,
    input  logic         div_rdy,
    input  logic         ld_valid,
    input  logic [W-1:0] ld_data,
    output logic         stall_ex,
    output logic         rf_we,
    output logic [4:0]   rf_waddr,
    output logic [W-1:0] rf_wdata,
    output logic         wb_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TERM_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_MUL, WAIT_DIV, WAIT_LD} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [4:0]    cap_rd;
    logic          cap_use;
    logic [2:0]    cap_funct3;
    logic [1:0]    cap_off;

    logic [W-1:0]  alu_value;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [W-1:0]  ld_value;
    logic          unit_rdy;
    logic [W-1:0]  unit_value;

    // The two adder carry-out bits are not consumed by write-back.
    logic unused_adder_hi;
    assign unused_adder_hi = ^adder_result[W+1:W];

    // Upstream must freeze as soon as a multi-cycle op is offered, not one
    // cycle later, so the accept cycle itself already stalls.
    assign stall_ex = (state != IDLE) || (ex_valid && (ex_kind != 2'b00));

    always_comb begin
        alu_value = adder_result[W-1:0];
        case (alu_rslt_mux_sel)
            2'b01:   alu_value = shft_result;
            2'b10:   alu_value = arth_log_result;
            2'b11:   alu_value = jmp_pc4;
            default: alu_value = adder_result[W-1:0];
        endcase
    end

    // Load extraction uses the offset captured at accept time; the live
    // adder output belongs to whatever the stalled execute stage holds now.
    always_comb begin
        ld_byte  = ld_data[{cap_off, 3'b000} +: 8];
        ld_half  = ld_data[{cap_off[1], 4'b0000} +: 16];
        ld_value = ld_data;
        case (cap_funct3)
            3'b000:  ld_value = {{(W-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_value = {{(W-8){1'b0}}, ld_byte};
            3'b001:  ld_value = {{(W-16){ld_half[15]}}, ld_half};
            3'b101:  ld_value = {{(W-16){1'b0}}, ld_half};
            default: ld_value = ld_data;
        endcase
    end

    // Only the ready strobe belonging to the current wait state counts.
    always_comb begin
        unit_rdy   = 1'b0;
        unit_value = ld_value;
        case (state)
            WAIT_MUL: begin
                unit_rdy   = mul_rdy;
                unit_value = mul_result;
            end
            WAIT_DIV: begin
                unit_rdy   = div_rdy;
                unit_value = div_result;
            end
            WAIT_LD: begin
                unit_rdy   = ld_valid;
                unit_value = ld_value;
            end
            default: begin
                unit_rdy   = 1'b0;
                unit_value = ld_value;
            end
        endcase
    end

    // Completion FSM. rf_waddr/rf_wdata only move when a write is issued so
    // the forwarding path keeps presenting the last written value. A ready
    // in the terminal-count cycle is checked first and therefore wins.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            cap_rd     <= '0;
            cap_use    <= 1'b0;
            cap_funct3 <= '0;
            cap_off    <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            wb_err     <= 1'b0;
        end else begin
            rf_we  <= 1'b0;
            wb_err <= 1'b0;
            if (state == IDLE) begin
                if (ex_valid) begin
                    if (ex_kind == 2'b00) begin
                        if (ex_useRd && (ex_rd != 5'd0)) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= ex_rd;
                            rf_wdata <= alu_value;
                        end
                    end else begin
                        cap_rd     <= ex_rd;
                        cap_use    <= ex_useRd;
                        cap_funct3 <= ex_funct3;
                        cap_off    <= adder_result[1:0];
                        wait_cnt   <= '0;
                        case (ex_kind)
                            2'b01:   state <= WAIT_MUL;
                            2'b10:   state <= WAIT_DIV;
                            default: state <= WAIT_LD;
                        endcase
                    end
                end
            end else begin
                if (unit_rdy) begin
                    if (cap_use && (cap_rd != 5'd0)) begin
                        rf_we    <= 1'b1;
                        rf_waddr <= cap_rd;
                        rf_wdata <= unit_value;
                    end
                    state <= IDLE;
                end else if (wait_cnt == TERM_CNT) begin
                    wb_err <= 1'b1;
                    state  <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end
        end
    end

endmodule
